// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-port responder.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_PTR,
        ST_ACK_PTR,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_MACK,
        ST_IGNORE
    } state_e;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

    localparam logic [3:0] BYTE_BITS = 4'd8;

    // Upper seven bits of the first byte after START are the target address.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stable-sample filter for one asynchronous I2C line.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    logic       sync1_q, sync2_q;
    logic       level_q, rise_q, fall_q;
    logic [3:0] cnt_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // synchronizer chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C responder exposing an auto-incrementing 8-bit register pointer and a
// byte-wide register port; samples scl/sda on clk and never stretches the clock.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h5C,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (clk),
        .rst   (rst),
        .din   (scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       busy_q, busy_d;

    logic [7:0] shift_in;
    assign shift_in = {shift_q[6:0], sda_lvl};

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch so no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != BYTE_BITS) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == BYTE_BITS) begin
                        // Byte is committed only at the falling edge, so a
                        // START/STOP inside the 8th SCL-high phase drops it.
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            if (addr_match(shift_q, DEV_ADDR)) begin
                                state_d  = ST_ACK_ADDR;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                            end else begin
                                state_d  = ST_IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == ST_PTR) begin
                            reg_addr_d = shift_q;
                            state_d    = ST_ACK_PTR;
                            sda_oe_d   = 1'b1;
                        end else begin
                            reg_wdata_d = shift_q;
                            reg_we_d    = 1'b1;
                            state_d     = ST_ACK_W;
                            sda_oe_d    = 1'b1;
                        end
                    end
                end

                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (shift_q[0] == RW_READ) begin
                            reg_re_d = 1'b1;
                            state_d  = ST_RDATA;
                        end else begin
                            state_d = ST_PTR;
                        end
                    end
                end

                ST_ACK_PTR: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end

                ST_ACK_W: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        reg_addr_d = reg_addr_q + 8'd1;
                        state_d    = ST_WDATA;
                    end
                end

                ST_RDATA: begin
                    // Read data arrives one clk after the request; its MSB goes
                    // straight onto the line while SCL is still low.
                    if (reg_re_q) begin
                        tx_d     = reg_rdata;
                        sda_oe_d = ~reg_rdata[7];
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BYTE_BITS) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = ST_MACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end

                ST_MACK: begin
                    if (scl_rise) begin
                        ack_d      = sda_lvl;
                        reg_addr_d = reg_addr_q + 8'd1;
                    end else if (scl_fall) begin
                        if (ack_q == ACK) begin
                            reg_re_d = 1'b1;
                            state_d  = ST_RDATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end

                ST_IDLE, ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ack_q       <= NACK;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged initiator on an open-drain SDA
// model, combinational register file returning addr^0xFF.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int QCLK = 10;

    logic       clk;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'hFF;

    i2c_target #(.DEV_ADDR(7'h5C), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] we_addr_log[$];
    logic [7:0] we_data_log[$];
    int re_cnt   = 0;
    int oe_cnt   = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (reg_we) begin
            we_addr_log.push_back(reg_addr);
            we_data_log.push_back(reg_wdata);
        end
        if (reg_re) re_cnt++;
        if (sda_oe) oe_cnt++;
        if (busy)   busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic quarter();
        repeat (QCLK) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; quarter();
        scl   = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl   = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; quarter();
        scl   = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    // Glitch mode drops scl low for exactly one clk in every high phase.
    task automatic send_bits(input logic [7:0] b, input int n, input bit glitch);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; quarter();
            scl   = 1'b1; quarter();
            if (glitch) begin
                scl = 1'b0; @(posedge clk); #1;
                scl = 1'b1; @(posedge clk); #1;
            end
            quarter();
            scl = 1'b0; quarter();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
        send_bits(b, 8, glitch);
        sda_m = 1'b1; quarter();
        scl   = 1'b1; quarter();
        ack   = sda_line; quarter();
        scl   = 1'b0; quarter();
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; quarter();
            scl   = 1'b1; quarter();
            b[i]  = sda_line; quarter();
            scl   = 1'b0; quarter();
        end
        sda_m = ack; quarter();
        scl   = 1'b1; quarter(); quarter();
        scl   = 1'b0; quarter();
    endtask

    initial begin
        logic       a;
        logic [7:0] rb0, rb1;
        int         w0, r0, o0, b0;

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("rst_sda_oe",    32'(sda_oe),    32'h0);
        check("rst_reg_addr",  32'(reg_addr),  32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        check("rst_reg_we",    32'(reg_we),    32'h0);
        check("rst_reg_re",    32'(reg_re),    32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        rst = 1'b0;
        quarter();

        // Write 0xA5, 0x3C starting at register 0x10
        w0 = we_addr_log.size();
        i2c_start();
        write_byte(8'hB8, 1'b0, a); check("wr_ack_addr", 32'(a), 32'(ACK));
        write_byte(8'h10, 1'b0, a); check("wr_ack_ptr",  32'(a), 32'(ACK));
        write_byte(8'hA5, 1'b0, a); check("wr_ack_d0",   32'(a), 32'(ACK));
        write_byte(8'h3C, 1'b0, a); check("wr_ack_d1",   32'(a), 32'(ACK));
        check("wr_busy_before_stop", 32'(busy), 32'h1);
        i2c_stop();
        check("wr_busy_after_stop", 32'(busy), 32'h0);
        check("wr_we_count", 32'(we_addr_log.size() - w0), 32'd2);
        check("wr_we0_addr", 32'(we_addr_log[w0]),     32'h10);
        check("wr_we0_data", 32'(we_data_log[w0]),     32'hA5);
        check("wr_we1_addr", 32'(we_addr_log[w0 + 1]), 32'h11);
        check("wr_we1_data", 32'(we_data_log[w0 + 1]), 32'h3C);
        check("wr_reg_addr", 32'(reg_addr), 32'h12);
        quarter();

        // Combined write-pointer / repeated-START / read
        w0 = we_addr_log.size(); r0 = re_cnt;
        i2c_start();
        write_byte(8'hB8, 1'b0, a); check("rd_ack_addr_w", 32'(a), 32'(ACK));
        write_byte(8'h20, 1'b0, a); check("rd_ack_ptr",    32'(a), 32'(ACK));
        i2c_start();
        write_byte(8'hB9, 1'b0, a); check("rd_ack_addr_r", 32'(a), 32'(ACK));
        read_byte(ACK,  rb0);
        read_byte(NACK, rb1);
        i2c_stop();
        check("rd_byte0",    32'(rb0), 32'hDF);
        check("rd_byte1",    32'(rb1), 32'hDE);
        check("rd_re_count", 32'(re_cnt - r0), 32'd2);
        check("rd_no_we",    32'(we_addr_log.size() - w0), 32'd0);
        check("rd_reg_addr", 32'(reg_addr), 32'h22);
        check("rd_sda_oe",   32'(sda_oe), 32'h0);
        quarter();

        // Address mismatch: target must stay silent
        w0 = we_addr_log.size(); r0 = re_cnt; o0 = oe_cnt; b0 = busy_cnt;
        i2c_start();
        write_byte(8'hBA, 1'b0, a); check("mm_nack", 32'(a), 32'(NACK));
        write_byte(8'h11, 1'b0, a);
        write_byte(8'h22, 1'b0, a);
        i2c_stop();
        check("mm_sda_oe_cycles", 32'(oe_cnt - o0),   32'd0);
        check("mm_busy_cycles",   32'(busy_cnt - b0), 32'd0);
        check("mm_no_we", 32'(we_addr_log.size() - w0), 32'd0);
        check("mm_no_re", 32'(re_cnt - r0), 32'd0);
        quarter();

        // Pointer wrap from 0xFF
        w0 = we_addr_log.size();
        i2c_start();
        write_byte(8'hB8, 1'b0, a);
        write_byte(8'hFF, 1'b0, a);
        write_byte(8'h11, 1'b0, a); check("wrap_ack_d0", 32'(a), 32'(ACK));
        write_byte(8'h22, 1'b0, a); check("wrap_ack_d1", 32'(a), 32'(ACK));
        i2c_stop();
        check("wrap_we_count", 32'(we_addr_log.size() - w0), 32'd2);
        check("wrap_we0_addr", 32'(we_addr_log[w0]),     32'hFF);
        check("wrap_we0_data", 32'(we_data_log[w0]),     32'h11);
        check("wrap_we1_addr", 32'(we_addr_log[w0 + 1]), 32'h00);
        check("wrap_we1_data", 32'(we_data_log[w0 + 1]), 32'h22);
        check("wrap_reg_addr", 32'(reg_addr), 32'h01);
        quarter();

        // SCL glitches are filtered, then a STOP after 5 bits drops the byte
        w0 = we_addr_log.size();
        i2c_start();
        write_byte(8'hB8, 1'b0, a);
        write_byte(8'h40, 1'b0, a);
        write_byte(8'h5A, 1'b1, a); check("gl_ack", 32'(a), 32'(ACK));
        send_bits(8'hC3, 5, 1'b0);
        i2c_stop();
        check("gl_we_count", 32'(we_addr_log.size() - w0), 32'd1);
        check("gl_we_addr",  32'(we_addr_log[w0]), 32'h40);
        check("gl_we_data",  32'(we_data_log[w0]), 32'h5A);
        check("ab_reg_addr", 32'(reg_addr), 32'h41);
        check("ab_sda_oe",   32'(sda_oe), 32'h0);
        check("ab_busy",     32'(busy), 32'h0);
        check("ab_state",    32'(dut.state_q), 32'(ST_IDLE));
        quarter();

        // Reset while the pointer byte is being ACKed
        i2c_start();
        write_byte(8'hB8, 1'b0, a);
        send_bits(8'h30, 8, 1'b0);
        check("rs_acking", 32'(sda_oe), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rs_sda_oe_next_clk", 32'(sda_oe),    32'h0);
        check("rs_reg_addr",        32'(reg_addr),  32'h0);
        check("rs_reg_wdata",       32'(reg_wdata), 32'h0);
        check("rs_reg_we",          32'(reg_we),    32'h0);
        check("rs_reg_re",          32'(reg_re),    32'h0);
        check("rs_busy",            32'(busy),      32'h0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        sda_m = 1'b1; scl = 1'b1;
        quarter(); quarter();
        w0 = we_addr_log.size();
        i2c_start();
        write_byte(8'hB8, 1'b0, a); check("rs_ack_addr", 32'(a), 32'(ACK));
        write_byte(8'h50, 1'b0, a); check("rs_ack_ptr",  32'(a), 32'(ACK));
        write_byte(8'h77, 1'b0, a); check("rs_ack_d0",   32'(a), 32'(ACK));
        i2c_stop();
        check("rs_we_count", 32'(we_addr_log.size() - w0), 32'd1);
        check("rs_we_addr",  32'(we_addr_log[w0]), 32'h50);
        check("rs_we_data",  32'(we_data_log[w0]), 32'h77);
        check("rs_reg_addr_after", 32'(reg_addr), 32'h51);
        quarter();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
